// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD controller: FSM states, datapath mux
// select encodings and the default operand width.
package gcd_pkg;

  localparam int GCD_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } state_e;

  localparam logic [1:0] SEL_A_LOAD = 2'b00;
  localparam logic [1:0] SEL_A_SUB  = 2'b01;
  localparam logic [1:0] SEL_A_B    = 2'b10;
  localparam logic [1:0] SEL_A_ZERO = 2'b11;

  localparam logic [1:0] SEL_B_LOAD = 2'b00;
  localparam logic [1:0] SEL_B_A    = 2'b01;
  localparam logic [1:0] SEL_B_B    = 2'b10;
  localparam logic [1:0] SEL_B_ZERO = 2'b11;

endpackage

// File: rtl/gcd_ctrl.sv
// Control FSM for the subtract/swap GCD datapath: accepts operand pairs,
// steers the datapath until breg==0, then holds the result for handoff.
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH,
  parameter int CNT_W = WIDTH + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  output logic [1:0]       sel_a,
  output logic [1:0]       sel_b,
  output logic             en_a,
  output logic             en_b,
  input  logic             beq0,
  input  logic             agtb,
  input  logic [WIDTH-1:0] res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_cycles
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign dp_a       = in_a;
  assign dp_b       = in_b;
  assign out_data   = res;
  assign out_cycles = cnt_q;
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_a   = SEL_A_LOAD;
    sel_b   = SEL_B_LOAD;
    en_a    = 1'b0;
    en_b    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          en_a    = 1'b1;
          en_b    = 1'b1;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Terminating cycle is counted too; saturate rather than wrap.
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        if (beq0) begin
          state_d = DONE;
        end else if (agtb) begin
          sel_a = SEL_A_SUB;
          en_a  = 1'b1;
        end else begin
          sel_a = SEL_A_B;
          sel_b = SEL_B_A;
          en_a  = 1'b1;
          en_b  = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
